// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and types for the branch resolve unit: opcodes, branch
// condition codes, the BHT counter reset value and the redirect FSM states.
package branch_resolve_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not-taken
  localparam logic [1:0] BHT_RESET = 2'b01;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Direct-mapped table of 2-bit saturating branch counters with one
// combinational read port (returns the stored, pre-update value) and one write port.
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  localparam int IDX_W = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr_q [BHT_ENTRIES];

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= BHT_RESET;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= ctr_step(ctr_q[wr_idx], wr_taken);
    end
  end

  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: compares the actual outcome with the
// fetch prediction, holds a redirect until fetch accepts it, trains the BHT.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [6:0]        is_opcode,
  input  logic [2:0]        is_func3,
  input  logic [XLEN-1:0]   is_pc,
  input  logic [XLEN-1:0]   is_rs1_data,
  input  logic [XLEN-1:0]   is_rs2_data,
  input  logic [XLEN-1:0]   i_imm,
  input  logic              i_pred_taken,
  input  logic [XLEN-1:0]   i_pred_target,
  output logic              o_redirect_valid,
  output logic [XLEN-1:0]   o_redirect_pc,
  input  logic              i_redirect_ready,
  output logic              o_flush,
  output logic [XLEN-1:0]   o_link_pc,
  input  logic [XLEN-1:0]   i_fetch_pc,
  output logic              o_fetch_pred_taken,
  output logic [PERF_W-1:0] o_perf_branches,
  output logic [PERF_W-1:0] o_perf_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  state_t                   state_q, state_d;
  logic                     accept, is_br, is_jal, is_jalr, is_ctrl;
  logic                     cond_taken, act_taken, mispred, capture;
  logic signed [XLEN-1:0]   rs1_s, rs2_s;
  logic        [XLEN-1:0]   jalr_sum, target, pc_seq, next_pc;
  logic        [XLEN-1:0]   redirect_pc_p1, link_pc_p1;
  logic                     flush_p1;
  logic        [PERF_W-1:0] perf_br_p1, perf_mp_p1;
  logic                     unused_bits;

  assign is_br   = (is_opcode == OPC_BRANCH);
  assign is_jal  = (is_opcode == OPC_JAL);
  assign is_jalr = (is_opcode == OPC_JALR);
  assign is_ctrl = is_br | is_jal | is_jalr;
  assign accept  = i_valid && (state_q == ST_IDLE);

  assign rs1_s = is_rs1_data;
  assign rs2_s = is_rs2_data;

  always_comb begin
    cond_taken = 1'b0;
    case (is_func3)
      F3_BEQ:  cond_taken = (is_rs1_data == is_rs2_data);
      F3_BNE:  cond_taken = (is_rs1_data != is_rs2_data);
      F3_BLT:  cond_taken = (rs1_s <  rs2_s);
      F3_BGE:  cond_taken = (rs1_s >= rs2_s);
      F3_BLTU: cond_taken = (is_rs1_data <  is_rs2_data);
      F3_BGEU: cond_taken = (is_rs1_data >= is_rs2_data);
      default: cond_taken = 1'b0;
    endcase
  end

  assign act_taken = is_jal | is_jalr | (is_br & cond_taken);
  assign jalr_sum  = is_rs1_data + i_imm;
  assign target    = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (is_pc + i_imm);
  assign pc_seq    = is_pc + XLEN'(4);
  assign next_pc   = act_taken ? target : pc_seq;
  // Right direction is not enough when taken: the predicted target must match too
  assign mispred   = is_ctrl &&
                     ((act_taken != i_pred_taken) || (act_taken && (i_pred_target != target)));
  assign capture   = accept && mispred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    o_ready          = 1'b0;
    o_redirect_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid && mispred) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        o_redirect_valid = 1'b1;
        if (i_redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: registered redirect, link and counters, all updated at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc_p1 <= '0;
      flush_p1       <= 1'b0;
      link_pc_p1     <= '0;
      perf_br_p1     <= '0;
      perf_mp_p1     <= '0;
    end else begin
      flush_p1 <= capture;
      if (capture) redirect_pc_p1 <= next_pc;
      if (accept && (is_jal || is_jalr)) link_pc_p1 <= pc_seq;
      if (accept && is_ctrl) perf_br_p1 <= sat_inc(perf_br_p1);
      if (capture) perf_mp_p1 <= sat_inc(perf_mp_p1);
    end
  end

  assign o_redirect_pc      = redirect_pc_p1;
  assign o_flush            = flush_p1;
  assign o_link_pc          = link_pc_p1;
  assign o_perf_branches    = perf_br_p1;
  assign o_perf_mispredicts = perf_mp_p1;

  bht_2bit #(
    .BHT_ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (i_fetch_pc[IDX_W+1:2]),
    .rd_taken (o_fetch_pred_taken),
    .wr_en    (accept && is_br),
    .wr_idx   (is_pc[IDX_W+1:2]),
    .wr_taken (cond_taken)
  );

  assign unused_bits = ^{i_fetch_pc[XLEN-1:IDX_W+2], i_fetch_pc[1:0], jalr_sum[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference model predicts redirects,
// BHT predictions and counters; a monitor checks every captured redirect.
module tb_branch_resolve_unit;

  localparam logic [6:0] BR = 7'h63, JAL = 7'h6F, JALR = 7'h67, ALU = 7'h33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, i_pred_taken = 1'b0, i_redirect_ready = 1'b0;
  logic [6:0]  is_opcode = '0;
  logic [2:0]  is_func3 = '0;
  logic [31:0] is_pc = '0, is_rs1_data = '0, is_rs2_data = '0, i_imm = '0;
  logic [31:0] i_pred_target = '0, i_fetch_pc = '0;
  logic        o_ready, o_redirect_valid, o_flush, o_fetch_pred_taken;
  logic [31:0] o_redirect_pc, o_link_pc, o_perf_branches, o_perf_mispredicts;
  logic        s_ready, s_redirect_valid, s_flush, s_fetch_pred_taken;
  logic [31:0] s_redirect_pc, s_link_pc;
  logic [1:0]  s_perf_branches, s_perf_mispredicts;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .is_opcode(is_opcode), .is_func3(is_func3), .is_pc(is_pc),
    .is_rs1_data(is_rs1_data), .is_rs2_data(is_rs2_data), .i_imm(i_imm),
    .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .i_redirect_ready(i_redirect_ready), .o_flush(o_flush), .o_link_pc(o_link_pc),
    .i_fetch_pc(i_fetch_pc), .o_fetch_pred_taken(o_fetch_pred_taken),
    .o_perf_branches(o_perf_branches), .o_perf_mispredicts(o_perf_mispredicts)
  );

  // Small instance: 2-entry BHT and 2-bit counters to reach saturation quickly
  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(2), .PERF_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(s_ready),
    .is_opcode(is_opcode), .is_func3(is_func3), .is_pc(is_pc),
    .is_rs1_data(is_rs1_data), .is_rs2_data(is_rs2_data), .i_imm(i_imm),
    .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
    .o_redirect_valid(s_redirect_valid), .o_redirect_pc(s_redirect_pc),
    .i_redirect_ready(i_redirect_ready), .o_flush(s_flush), .o_link_pc(s_link_pc),
    .i_fetch_pc(i_fetch_pc), .o_fetch_pred_taken(s_fetch_pred_taken),
    .o_perf_branches(s_perf_branches), .o_perf_mispredicts(s_perf_mispredicts)
  );

  int          total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hold_pc = '0;
  int          bht_m[64];
  int          bht_s[2];
  longint      br_cnt = 0, mp_cnt = 0;
  logic [31:0] link_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit taken_of(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b);
    if (op == JAL || op == JALR) return 1'b1;
    if (op != BR) return 1'b0;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] target_of(input logic [6:0] op, input logic [31:0] pc,
                                            input logic [31:0] a, input logic [31:0] imm);
    logic [31:0] s;
    if (op == JALR) begin
      s = a + imm;
      return s & 32'hFFFF_FFFE;
    end
    return pc + imm;
  endfunction

  function automatic longint sat3(input longint v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    for (int i = 0; i < 2; i++) bht_s[i] = 1;
    br_cnt = 0;
    mp_cnt = 0;
    link_m = '0;
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_perf_branches"}, o_perf_branches, br_cnt);
    chk({tag, "_perf_mispredicts"}, o_perf_mispredicts, mp_cnt);
    chk({tag, "_perf_branches_sat"}, s_perf_branches, sat3(br_cnt));
    chk({tag, "_perf_mispredicts_sat"}, s_perf_mispredicts, sat3(mp_cnt));
  endtask

  // Called at a negedge with the unit idle; returns at a negedge
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt, input int rr_delay,
                       input bit wait_idle);
    bit          ctrl, tk, mp;
    logic [31:0] tgt, npc;
    int          k;
    ctrl = (op == BR) || (op == JAL) || (op == JALR);
    tk   = taken_of(op, f3, a, b);
    tgt  = target_of(op, pc, a, imm);
    npc  = tk ? tgt : pc + 32'd4;
    mp   = ctrl && ((tk != pt) || (tk && ptgt != tgt));
    chk("ready_before_issue", o_ready, 1'b1);
    i_valid = 1'b1; is_opcode = op; is_func3 = f3; is_pc = pc;
    is_rs1_data = a; is_rs2_data = b; i_imm = imm;
    i_pred_taken = pt; i_pred_target = ptgt; i_fetch_pc = pc;
    i_redirect_ready = (rr_delay == 0);
    #1;
    chk("fetch_pred", o_fetch_pred_taken, bht_m[pc[7:2]] >= 2);
    chk("fetch_pred_small", s_fetch_pred_taken, bht_s[pc[2]] >= 2);
    if (mp) exp_q.push_back(npc);
    @(posedge clk);
    if (op == BR) begin
      bht_m[pc[7:2]] = tk ? ((bht_m[pc[7:2]] == 3) ? 3 : bht_m[pc[7:2]] + 1)
                          : ((bht_m[pc[7:2]] == 0) ? 0 : bht_m[pc[7:2]] - 1);
      bht_s[pc[2]]   = tk ? ((bht_s[pc[2]] == 3) ? 3 : bht_s[pc[2]] + 1)
                          : ((bht_s[pc[2]] == 0) ? 0 : bht_s[pc[2]] - 1);
    end
    if (ctrl) br_cnt++;
    if (mp) mp_cnt++;
    if (op == JAL || op == JALR) link_m = pc + 32'd4;
    @(negedge clk);
    i_valid = 1'b0;
    chk("redirect_pending", o_redirect_valid, mp);
    chk("link_pc", o_link_pc, link_m);
    check_counters("issue");
    if (wait_idle) begin
      k = 1;
      while (!o_ready && k < 20) begin
        i_redirect_ready = (k >= rr_delay);
        @(negedge clk);
        k++;
      end
      if (!o_ready) begin
        total++; bad++;
        $display("FAIL idle_timeout: o_ready=%0b expected 1", o_ready);
      end
    end
  endtask

  // Scoreboard monitor: every flush pulse must match the next expected redirect
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_flush) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_redirect: got pc %0h expected none", o_redirect_pc);
        end else begin
          hold_pc = exp_q.pop_front();
          chk("redirect_pc", o_redirect_pc, hold_pc);
          chk("valid_with_flush", o_redirect_valid, 1'b1);
        end
      end else if (o_redirect_valid) begin
        chk("redirect_pc_stable", o_redirect_pc, hold_pc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    logic [31:0] pc, a, b, imm, ptgt;
    int          sel;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_redirect_valid", o_redirect_valid, 1'b0);
    chk("reset_redirect_pc", o_redirect_pc, 32'h0);
    chk("reset_flush", o_flush, 1'b0);
    chk("reset_link_pc", o_link_pc, 32'h0);
    chk("reset_ready", o_ready, 1'b1);
    check_counters("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);

    issue(BR, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0, 0, 1'b1);
    issue(BR, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0, 1, 1'b1);
    issue(BR, 3'd4, 32'h204, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0, 2, 1'b1);
    issue(JALR, 3'd0, 32'h300, 32'h2001, 32'd0, 32'd2, 1'b1, 32'h2002, 0, 1'b1);
    issue(JALR, 3'd0, 32'h304, 32'h2001, 32'd0, 32'd2, 1'b1, 32'h2000, 1, 1'b1);
    issue(JAL, 3'd0, 32'h308, 32'd0, 32'd0, 32'hFFFF_FFF0, 1'b0, 32'h0, 0, 1'b1);

    // Redirect held for three cycles while further requests are dropped
    issue(BR, 3'd1, 32'h500, 32'd1, 32'd2, 32'h80, 1'b0, 32'h0, 5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; is_opcode = BR; is_func3 = 3'd1; is_pc = 32'h504;
      is_rs1_data = 32'd7; is_rs2_data = 32'd8; i_pred_taken = 1'b0;
      @(negedge clk);
      chk("held_ready", o_ready, 1'b0);
      check_counters("dropped");
    end
    i_valid = 1'b0;
    i_redirect_ready = 1'b1;
    @(negedge clk);
    chk("released_ready", o_ready, 1'b1);
    chk("released_valid", o_redirect_valid, 1'b0);

    // BHT training at one PC: up three times, down twice, then re-trained
    for (int i = 0; i < 3; i++) issue(BR, 3'd0, 32'h400, 32'd3, 32'd3, 32'h10, 1'b1, 32'h410, 0, 1'b1);
    for (int i = 0; i < 2; i++) issue(BR, 3'd1, 32'h400, 32'd3, 32'd3, 32'h10, 1'b0, 32'h0, 0, 1'b1);
    issue(ALU, 3'd0, 32'h400, 32'd0, 32'd0, 32'd0, 1'b1, 32'h0, 0, 1'b1);
    for (int i = 0; i < 2; i++) issue(BR, 3'd7, 32'h400, 32'd9, 32'd3, 32'h10, 1'b1, 32'h410, 0, 1'b1);

    // Asynchronous reset while a redirect is pending
    issue(BR, 3'd0, 32'h400, 32'd3, 32'd3, 32'h10, 1'b0, 32'h0, 9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_redirect_valid", o_redirect_valid, 1'b0);
    chk("arst_redirect_pc", o_redirect_pc, 32'h0);
    chk("arst_flush", o_flush, 1'b0);
    chk("arst_link_pc", o_link_pc, 32'h0);
    chk("arst_ready", o_ready, 1'b1);
    check_counters("arst");
    i_redirect_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    i_fetch_pc = 32'h400;
    #1;
    chk("arst_bht_pred", o_fetch_pred_taken, 1'b0);
    chk("arst_no_redirect", o_redirect_valid, 1'b0);
    @(negedge clk);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 6) ? BR : (sel == 6) ? JAL : (sel == 7) ? JALR : ALU;
      pc  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = $urandom;
        2: b = 32'hFFFF_FFFF;
        default: b = 32'h8000_0000;
      endcase
      imm  = $urandom_range(0, 1) ? $urandom : 32'($signed(12'($urandom)));
      ptgt = $urandom_range(0, 1) ? target_of(op, pc, a, imm) : $urandom;
      issue(op, 3'($urandom_range(0, 7)), pc, a, b, imm, 1'($urandom_range(0, 1)), ptgt,
            $urandom_range(0, 3), 1'b1);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
